// File: rtl/spi_arb_pkg.sv
`default_nettype none
//============================================================================
// Module   : spi_arb_pkg
// Purpose  : Shared definitions for the SPI bus arbiter: engine word width,
//            default watchdog timeout and the arbiter FSM state encoding.
// Ports    : none (package)
// Revision : 1.0  initial release
//============================================================================
package spi_arb_pkg;

   localparam int SPI_WORD_W             = 32;
   localparam int DEFAULT_TIMEOUT_CYCLES = 4096;

   // Arbiter FSM state; binary encoded, kept as plain constants so older
   // code that compares raw state values keeps working.
   typedef logic [1:0] arbState_t;
   localparam arbState_t c_IDLE   = 2'd0;
   localparam arbState_t c_LAUNCH = 2'd1;
   localparam arbState_t c_WAIT   = 2'd2;

endpackage
`default_nettype wire

// File: rtl/spi_bus_arbiter_rr_pick.sv
`default_nettype none
//============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin picker. Selects the first pending
//            index at or after the pointer, wrapping modulo NUM_REQ.
// Ports    : pending      in  NUM_REQ  request vector
//            pointer      in  PTR_W    search start index
//            winnerOneHot out NUM_REQ  one-hot winner (zero if none pending)
//            winnerIdx    out PTR_W    binary winner index
//            anyPending   out 1        at least one request pending
// Revision : 1.0  initial release
//============================================================================
module rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int PTR_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] pending,
   input  logic [PTR_W-1:0]   pointer,
   output logic [NUM_REQ-1:0] winnerOneHot,
   output logic [PTR_W-1:0]   winnerIdx,
   output logic               anyPending
);

   assign anyPending = |pending;

   // Scan offsets from farthest to nearest so the nearest pending slot
   // (relative to the pointer) is the last assignment and therefore wins.
   always_comb begin
      logic [PTR_W:0] w_slot;
      winnerIdx = '0;
      w_slot    = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         w_slot = {1'b0, pointer} + (PTR_W+1)'(k);
         if (w_slot >= (PTR_W+1)'(NUM_REQ)) begin
            w_slot = w_slot - (PTR_W+1)'(NUM_REQ);
         end
         if (pending[w_slot[PTR_W-1:0]]) begin
            winnerIdx = w_slot[PTR_W-1:0];
         end
      end
   end

   always_comb begin
      winnerOneHot            = '0;
      winnerOneHot[winnerIdx] = anyPending;
   end

endmodule
`default_nettype wire

// File: rtl/spi_bus_arbiter.sv
`default_nettype none
//============================================================================
// Module   : spi_bus_arbiter
// Purpose  : Shares one SPI master engine among NUM_REQ sequencers. Start
//            pulses are queued in a pending register, the engine is granted
//            round-robin, the owner's TX word is replayed to the engine and
//            DONE/RX are routed back to the owner.
// Config   : SPI_ARB_WATCHDOG_EN - when defined, a WAIT-state watchdog
//            aborts a transaction after TIMEOUT_CYCLES and flags ReqError.
// Ports    : SysClock   in  1           system clock (posedge)
//            SysReset_n in  1           synchronous active-low reset
//            ReqStart   in  NUM_REQ     per-requester start pulse
//            ReqTX      in  32*NUM_REQ  packed per-requester TX words
//            ReqDone    out NUM_REQ     completion pulse to owner
//            ReqGrant   out NUM_REQ     one-hot current owner
//            ReqRX      out 32          RX word of last completion
//            ReqError   out 1           last completion was a watchdog abort
//            SPI_TX     out 32          word to engine
//            SPI_START  out 1           engine start pulse
//            SPI_DONE   in  1           engine completion
//            SPI_RX     in  32          engine receive word
// Revision : 1.0  initial release
//============================================================================
module spi_bus_arbiter
   import spi_arb_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic                          SysClock,
   input  logic                          SysReset_n,
   input  logic [NUM_REQ-1:0]            ReqStart,
   input  logic [SPI_WORD_W*NUM_REQ-1:0] ReqTX,
   output logic [NUM_REQ-1:0]            ReqDone,
   output logic [NUM_REQ-1:0]            ReqGrant,
   output logic [SPI_WORD_W-1:0]         ReqRX,
   output logic                          ReqError,
   output logic [SPI_WORD_W-1:0]         SPI_TX,
   output logic                          SPI_START,
   input  logic                          SPI_DONE,
   input  logic [SPI_WORD_W-1:0]         SPI_RX
);

   localparam int c_PTR_W = $clog2(NUM_REQ);

   arbState_t               r_state;
   logic [NUM_REQ-1:0]      r_pending;
   logic [c_PTR_W-1:0]      r_pointer;
   logic [c_PTR_W-1:0]      r_ownerIdx;
   logic [NUM_REQ-1:0]      r_grant;
   logic [NUM_REQ-1:0]      r_done;
   logic [SPI_WORD_W-1:0]   r_rx;
   logic [SPI_WORD_W-1:0]   r_tx;
   logic                    r_start;

   logic [NUM_REQ-1:0]      w_winOneHot;
   logic [c_PTR_W-1:0]      w_winIdx;
   logic                    w_anyPending;
   logic                    w_launch;
   logic [NUM_REQ-1:0]      w_clearMask;
   logic [c_PTR_W-1:0]      w_nextPointer;
   logic                    w_timeout;
   logic                    w_finish;
   logic [SPI_WORD_W-1:0]   w_txSlice [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_txSlice
      assign w_txSlice[g] = ReqTX[SPI_WORD_W*g +: SPI_WORD_W];
   end

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (c_PTR_W)
   ) u_rrPick (
      .pending      (r_pending),
      .pointer      (r_pointer),
      .winnerOneHot (w_winOneHot),
      .winnerIdx    (w_winIdx),
      .anyPending   (w_anyPending)
   );

   assign w_launch    = (r_state == c_IDLE) && w_anyPending;
   assign w_clearMask = w_launch ? w_winOneHot : '0;

   // Pointer moves to the slot after the owner, wrapping for non-power-of-2
   // requester counts.
   assign w_nextPointer = (r_ownerIdx == c_PTR_W'(NUM_REQ - 1)) ? '0
                                                                 : r_ownerIdx + 1'b1;

`ifdef SPI_ARB_WATCHDOG_EN
   localparam int c_WD_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [c_WD_W-1:0] r_wdCount;
   logic [c_WD_W-1:0] w_wdNext;
   logic              r_error;

   assign w_wdNext  = r_wdCount + 1'b1;
   // Fires on the WAIT edge at which the count would reach the limit.
   assign w_timeout = (r_state == c_WAIT) && (w_wdNext == c_WD_W'(TIMEOUT_CYCLES));

   always_ff @(posedge SysClock) begin
      if (!SysReset_n) begin
         r_wdCount <= '0;
         r_error   <= 1'b0;
      end else begin
         if (r_state == c_LAUNCH) begin
            r_wdCount <= '0;
         end else if (r_state == c_WAIT) begin
            r_wdCount <= w_wdNext;
         end
         // SPI_DONE wins over a coincident timeout.
         if (w_finish) begin
            r_error <= !SPI_DONE;
         end
      end
   end

   assign ReqError = r_error;
`else
   logic w_unusedTimeout;

   // Keeps the timeout parameter referenced when no watchdog is built.
   assign w_unusedTimeout = (TIMEOUT_CYCLES != 0);
   assign w_timeout       = 1'b0;
   assign ReqError        = 1'b0;
`endif

   assign w_finish = (r_state == c_WAIT) && (SPI_DONE || w_timeout);

   always_ff @(posedge SysClock) begin
      if (!SysReset_n) begin
         r_state    <= c_IDLE;
         r_pending  <= '0;
         r_pointer  <= '0;
         r_ownerIdx <= '0;
         r_grant    <= '0;
         r_done     <= '0;
         r_rx       <= '0;
         r_tx       <= '0;
         r_start    <= 1'b0;
      end else begin
         r_start <= 1'b0;
         r_done  <= '0;
         // New starts are OR-ed after the grant clear, so a start that
         // coincides with its own grant stays queued.
         r_pending <= (r_pending & ~w_clearMask) | ReqStart;

         case (r_state)
            c_IDLE: begin
               if (w_anyPending) begin
                  r_tx       <= w_txSlice[w_winIdx];
                  r_grant    <= w_winOneHot;
                  r_ownerIdx <= w_winIdx;
                  r_start    <= 1'b1;
                  r_state    <= c_LAUNCH;
               end
            end
            c_LAUNCH: begin
               r_state <= c_WAIT;
            end
            c_WAIT: begin
               if (w_finish) begin
                  r_rx      <= SPI_DONE ? SPI_RX : '0;
                  r_done    <= r_grant;
                  r_grant   <= '0;
                  r_pointer <= w_nextPointer;
                  r_state   <= c_IDLE;
               end
            end
            default: begin
               r_state <= c_IDLE;
            end
         endcase
      end
   end

   assign ReqDone   = r_done;
   assign ReqGrant  = r_grant;
   assign ReqRX     = r_rx;
   assign SPI_TX    = r_tx;
   assign SPI_START = r_start;

endmodule
`default_nettype wire
